// File: rtl/multi_lane_fifo_if.sv
// Handshake bundle for multi_lane_fifo: LANES-wide enqueue and dequeue groups plus occupancy.
// The master side feeds enqueues and consumes dequeues; the slave side is the queue itself.
interface multi_lane_fifo_if #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int LANES      = 2
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [LANES-1:0]            enq_valid;
   logic [LANES*DATA_WIDTH-1:0] enq_data;
   logic                        enq_ready;
   logic [LANES-1:0]            deq_valid;
   logic [LANES*DATA_WIDTH-1:0] deq_data;
   logic [LANES-1:0]            deq_ready;
   logic [CW-1:0]               count;

   modport master (
      output enq_valid, enq_data, deq_ready,
      input  enq_ready, deq_valid, deq_data, count
   );

   modport slave (
      input  enq_valid, enq_data, deq_ready,
      output enq_ready, deq_valid, deq_data, count
   );
endinterface

// File: rtl/multi_lane_fifo.sv
// Multi-lane circular queue: up to LANES in-order enqueues and dequeues per cycle.
// Define MULTI_LANE_FIFO_BYPASS_EN to forward same-cycle enqueues straight to empty dequeue lanes.
module multi_lane_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int LANES      = 2
) (
   input logic               clk,
   input logic               rst,
   input logic               flush,
   multi_lane_fifo_if.slave  bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] ENQ_LIMIT = CW'(DEPTH - LANES);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]         head;
   logic [CW-1:0]         tail;
   logic [CW-1:0]         count_q;

   logic [LANES-1:0]      enq_mask;
   logic [LANES-1:0]      deq_mask;
   logic [LANES-1:0]      wr_en;
   logic [CW-1:0]         n_enq;
   logic [CW-1:0]         n_deq;

   function automatic logic [CW-1:0] popcount(input logic [LANES-1:0] v);
      logic [CW-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < LANES; i++) begin
         if (v[i]) cnt = cnt + CW'(1);
      end
      return cnt;
   endfunction

   function automatic logic [AW-1:0] slot(input logic [CW-1:0] p);
      return AW'(p % DEPTH);
   endfunction

   // Ready looks only at the registered count, so no same-cycle dequeue can loosen it.
   assign bus.enq_ready = (count_q <= ENQ_LIMIT);
   assign bus.count     = count_q;
   assign enq_mask      = bus.enq_ready ? bus.enq_valid : '0;
   assign n_enq         = popcount(enq_mask);
   assign deq_mask      = bus.deq_ready & bus.deq_valid;
   assign n_deq         = popcount(deq_mask);

`ifdef MULTI_LANE_FIFO_BYPASS_EN
   logic [CW:0] avail;
   logic [CW:0] fwd_used;

   assign avail = {1'b0, count_q} + {1'b0, n_enq};

   // Lanes beyond the stored entries pick up this cycle's enqueue lanes in order.
   always_comb begin
      bus.deq_valid = '0;
      bus.deq_data  = '0;
      for (int i = 0; i < LANES; i++) begin
         bus.deq_valid[i] = avail > (CW+1)'(i);
         bus.deq_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[slot(head + CW'(i))];
         if (!(count_q > CW'(i))) begin
            for (int j = 0; j < LANES; j++) begin
               if (({1'b0, count_q} + (CW+1)'(j)) == (CW+1)'(i)) begin
                  bus.deq_data[i*DATA_WIDTH +: DATA_WIDTH] = bus.enq_data[j*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end
      end
   end

   // Enqueue lanes already consumed through the bypass never land in storage.
   always_comb begin
      fwd_used = ({1'b0, n_deq} > {1'b0, count_q}) ? ({1'b0, n_deq} - {1'b0, count_q}) : '0;
      wr_en    = '0;
      for (int j = 0; j < LANES; j++) begin
         wr_en[j] = enq_mask[j] && ((CW+1)'(j) >= fwd_used);
      end
   end
`else
   always_comb begin
      bus.deq_valid = '0;
      bus.deq_data  = '0;
      for (int i = 0; i < LANES; i++) begin
         bus.deq_valid[i] = count_q > CW'(i);
         bus.deq_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[slot(head + CW'(i))];
      end
   end

   assign wr_en = enq_mask;
`endif

   // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         head    <= head + n_deq;
         tail    <= tail + n_enq;
         count_q <= count_q + n_enq - n_deq;
      end
   end

   // Storage is deliberately not cleared; stale contents sit behind deq_valid.
   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         for (int j = 0; j < LANES; j++) begin
            if (wr_en[j]) begin
               mem[slot(tail + CW'(j))] <= bus.enq_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end
endmodule

// File: tb/tb_multi_lane_fifo.sv
// Directed self-checking bench for multi_lane_fifo with DEPTH=8, LANES=2, DATA_WIDTH=8.
// Honours MULTI_LANE_FIFO_BYPASS_EN in the same-cycle forwarding check.
module tb_multi_lane_fifo;
   localparam int DATA_WIDTH = 8;
   localparam int DEPTH      = 8;
   localparam int LANES      = 2;

   logic clk;
   logic rst;
   logic flush;
   int   checks;
   int   failures;

   multi_lane_fifo_if #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .LANES(LANES)) bus ();

   multi_lane_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .LANES(LANES)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle's inputs, clock them in, then return the inputs to idle.
   task automatic applyStimulus(input logic [1:0] ev, input logic [15:0] ed,
                                input logic [1:0] dr, input logic fl, input logic rs);
      bus.enq_valid = ev;
      bus.enq_data  = ed;
      bus.deq_ready = dr;
      flush         = fl;
      rst           = rs;
      #1;
      @(posedge clk);
      #1;
      bus.enq_valid = 2'b00;
      bus.enq_data  = 16'h0000;
      bus.deq_ready = 2'b00;
      flush         = 1'b0;
      rst           = 1'b0;
      #1;
   endtask

   task automatic checkLanes(input string tag, input logic [7:0] lane0, input logic [7:0] lane1);
      checkOutput({tag, "_lane0"}, 64'(bus.deq_data[7:0]), 64'(lane0));
      checkOutput({tag, "_lane1"}, 64'(bus.deq_data[15:8]), 64'(lane1));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      bus.enq_valid = 2'b00;
      bus.enq_data  = 16'h0000;
      bus.deq_ready = 2'b00;
      flush = 1'b0;
      rst   = 1'b1;

      applyStimulus(2'b00, 16'h0000, 2'b00, 1'b0, 1'b1);
      applyStimulus(2'b00, 16'h0000, 2'b00, 1'b0, 1'b1);
      checkOutput("reset_count", 64'(bus.count), 64'd0);
      checkOutput("reset_deq_valid", 64'(bus.deq_valid), 64'd0);
      checkOutput("reset_enq_ready", 64'(bus.enq_ready), 64'd1);

      applyStimulus(2'b11, 16'h0201, 2'b00, 1'b0, 1'b0);
      checkOutput("first_count", 64'(bus.count), 64'd2);
      checkOutput("first_deq_valid", 64'(bus.deq_valid), 64'h3);
      checkLanes("first", 8'h01, 8'h02);

      applyStimulus(2'b00, 16'h0000, 2'b00, 1'b1, 1'b0);
      checkOutput("preflush_count", 64'(bus.count), 64'd0);

      for (int k = 0; k < 4; k++) begin
         applyStimulus(2'b11, {8'(8'h11 + 2*k), 8'(8'h10 + 2*k)}, 2'b00, 1'b0, 1'b0);
      end
      checkOutput("full_count", 64'(bus.count), 64'd8);
      checkOutput("full_enq_ready", 64'(bus.enq_ready), 64'd0);
      applyStimulus(2'b11, 16'hEEFF, 2'b00, 1'b0, 1'b0);
      checkOutput("full_blocked_count", 64'(bus.count), 64'd8);
      checkLanes("full_head", 8'h10, 8'h11);
      applyStimulus(2'b11, 16'hEEFF, 2'b11, 1'b0, 1'b0);
      checkOutput("full_enq_deq_count", 64'(bus.count), 64'd6);
      for (int k = 1; k < 4; k++) begin
         checkLanes("full_drain", 8'(8'h10 + 2*k), 8'(8'h11 + 2*k));
         applyStimulus(2'b00, 16'h0000, 2'b11, 1'b0, 1'b0);
      end
      checkOutput("full_drained_count", 64'(bus.count), 64'd0);
      checkOutput("full_drained_valid", 64'(bus.deq_valid), 64'd0);

      for (int k = 0; k < 3; k++) applyStimulus(2'b11, 16'hB1B0, 2'b00, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) applyStimulus(2'b00, 16'h0000, 2'b11, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(2'b11, {8'(8'hA1 + 2*k), 8'(8'hA0 + 2*k)}, 2'b00, 1'b0, 1'b0);
      end
      checkOutput("wrap_count", 64'(bus.count), 64'd6);
      for (int k = 0; k < 3; k++) begin
         checkLanes("wrap_drain", 8'(8'hA0 + 2*k), 8'(8'hA1 + 2*k));
         applyStimulus(2'b00, 16'h0000, 2'b11, 1'b0, 1'b0);
      end
      checkOutput("wrap_empty_count", 64'(bus.count), 64'd0);

      applyStimulus(2'b11, 16'hC1C0, 2'b00, 1'b0, 1'b0);
      applyStimulus(2'b01, 16'h00C2, 2'b00, 1'b0, 1'b0);
      checkOutput("mixed_start_count", 64'(bus.count), 64'd3);
      applyStimulus(2'b01, 16'h00C3, 2'b11, 1'b0, 1'b0);
      checkOutput("mixed_a_count", 64'(bus.count), 64'd2);
      checkLanes("mixed_a", 8'hC2, 8'hC3);
      applyStimulus(2'b11, 16'hC5C4, 2'b01, 1'b0, 1'b0);
      checkOutput("mixed_b_count", 64'(bus.count), 64'd3);
      checkLanes("mixed_b", 8'hC3, 8'hC4);
      applyStimulus(2'b00, 16'h0000, 2'b11, 1'b0, 1'b0);
      checkOutput("mixed_c_count", 64'(bus.count), 64'd1);
      checkOutput("mixed_c_lane0", 64'(bus.deq_data[7:0]), 64'hC5);
      checkOutput("mixed_c_valid", 64'(bus.deq_valid), 64'h1);
      applyStimulus(2'b00, 16'h0000, 2'b01, 1'b0, 1'b0);

      applyStimulus(2'b11, 16'hD1D0, 2'b00, 1'b0, 1'b0);
      applyStimulus(2'b11, 16'hD3D2, 2'b00, 1'b0, 1'b0);
      applyStimulus(2'b01, 16'h00D4, 2'b00, 1'b0, 1'b0);
      checkOutput("flush_pre_count", 64'(bus.count), 64'd5);
      applyStimulus(2'b11, 16'hEEEE, 2'b00, 1'b1, 1'b0);
      checkOutput("flush_count", 64'(bus.count), 64'd0);
      checkOutput("flush_deq_valid", 64'(bus.deq_valid), 64'd0);
      checkOutput("flush_enq_ready", 64'(bus.enq_ready), 64'd1);

      applyStimulus(2'b11, 16'hD1D0, 2'b00, 1'b0, 1'b0);
      applyStimulus(2'b11, 16'hD3D2, 2'b00, 1'b0, 1'b0);
      applyStimulus(2'b01, 16'h00D4, 2'b00, 1'b0, 1'b0);
      checkOutput("rst_pre_count", 64'(bus.count), 64'd5);
      applyStimulus(2'b11, 16'hEEEE, 2'b00, 1'b0, 1'b1);
      checkOutput("rst_count", 64'(bus.count), 64'd0);
      checkOutput("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
      checkOutput("rst_enq_ready", 64'(bus.enq_ready), 64'd1);

      bus.enq_valid = 2'b11;
      bus.enq_data  = 16'h6655;
      bus.deq_ready = 2'b01;
      #1;
`ifdef MULTI_LANE_FIFO_BYPASS_EN
      checkOutput("bypass_same_valid", 64'(bus.deq_valid), 64'h3);
      checkOutput("bypass_same_lane0", 64'(bus.deq_data[7:0]), 64'h55);
      applyStimulus(2'b11, 16'h6655, 2'b01, 1'b0, 1'b0);
      checkOutput("bypass_next_count", 64'(bus.count), 64'd1);
      checkOutput("bypass_next_lane0", 64'(bus.deq_data[7:0]), 64'h66);
`else
      checkOutput("nobypass_same_valid", 64'(bus.deq_valid), 64'd0);
      applyStimulus(2'b11, 16'h6655, 2'b01, 1'b0, 1'b0);
      checkOutput("nobypass_next_count", 64'(bus.count), 64'd2);
      checkLanes("nobypass_next", 8'h55, 8'h66);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule

// File: doc/multi_lane_fifo.md
Name: multi_lane_fifo

Overview:
- Parametrised circular queue with LANES enqueue ports and LANES dequeue ports per cycle, in program order.
- Serves as the general buffer between superscalar stages of the out-of-order core, e.g. fetch→decode instruction queue and dispatch→issue.
- Generalises the fixed 2-wide enq/deq vectors into arbitrary lane count, depth and data width.
- Adds occupancy count, flush, and optional same-cycle bypass.

Parameters:
- DATA_WIDTH, 32, bits per entry.
- DEPTH, 8, number of entries. Must be a power of 2 and ≥ LANES.
- LANES, 2, enqueue and dequeue lanes per cycle (≥1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous queue clear.
- enq_valid  input  LANES  per-lane enqueue request. Must be contiguous from bit 0 (thermometer form).
- enq_data  input  LANES*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- enq_ready  output  1  whole-group accept: 1 when free slots ≥ LANES.
- deq_valid  output  LANES  lane i holds the i-th oldest entry.
- deq_data  output  LANES*DATA_WIDTH  oldest entry on lane 0.
- deq_ready  input  LANES  per-lane consume request. Must be contiguous from bit 0.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage and pointers:
  - Storage is DEPTH×DATA_WIDTH registers.
  - head and tail pointers are $clog2(DEPTH)+1 bits wide; the extra MSB is the wrap bit.
  - Pointers index storage modulo DEPTH, so wrap-around is implicit.
- Enqueue:
  - n_enq = popcount(enq_valid) when enq_ready=1, else 0.
  - enq_ready depends only on registered count: enq_ready = (DEPTH − count) ≥ LANES. It is not a function of same-cycle dequeues, so there is no combinational ready→valid path.
  - Lane i writes storage[(tail+i) mod DEPTH]. Then tail ← tail + n_enq.
- Dequeue:
  - deq_valid[i] = (count > i).
  - deq_data lane i = storage[(head+i) mod DEPTH]. Output is combinational from storage, so entries appear 1 cycle after enqueue.
  - n_deq = popcount(deq_ready & deq_valid). Then head ← head + n_deq.
- Occupancy:
  - count ← count + n_enq − n_deq. Width is $clog2(DEPTH)+1.
  - count equals tail − head, including wrap bits.
- Simultaneous events:
  - Enqueue and dequeue in the same cycle are both applied.
  - When full (count=DEPTH): enq_ready=0, even if a dequeue fires that cycle.
  - When empty: deq_valid=0, and any deq_ready is ignored.
- Illegal patterns:
  - Non-contiguous enq_valid or deq_ready (e.g. 2'b10) is illegal.
  - Response is undefined, but head, tail and count must remain consistent: popcount of the masked vectors is still used.
- Flush:
  - head ← 0, tail ← 0, count ← 0 at the next edge.
  - Flush overrides any enqueue or dequeue in the same cycle.
  - Storage contents are not cleared.
- Reset:
  - Same effect as flush, and takes priority.
  - Output reset values: count=0, deq_valid=0, enq_ready=1 (DEPTH ≥ LANES).
  - deq_data is don't-care while deq_valid=0.
  - Reset asserted mid-operation discards all entries; nothing is retained.
- Latency: enqueue to deq_valid is 1 cycle (without bypass).

Optional Feature:
- Macro: MULTI_LANE_FIFO_BYPASS_EN.
- Defined:
  - Entries enqueued this cycle are forwarded combinationally to dequeue lanes not covered by stored entries.
  - deq_valid[i] = (count + n_enq) > i.
  - For i ≥ count, lane i data = enq lane (i − count).
  - Forwarded entries consumed that same cycle are never written to storage: tail and head both advance, and count reflects the net change.
  - Enqueue-to-dequeue latency is 0 cycles.
  - enq_ready remains registered-count based.
- Undefined: strict 1-cycle latency, as specified above.

Test Plan:
(Parameters DEPTH=8, LANES=2, DATA_WIDTH=8.)
- Reset: hold rst 2 cycles → count=0, deq_valid=2'b00, enq_ready=1. Next cycle, enq_valid=2'b11, data {8'h02,8'h01} → following cycle count=2, deq_valid=2'b11, lane0=8'h01, lane1=8'h02.
- Fill: enqueue 2'b11 for 4 cycles (8'h10..8'h17) → count=8, enq_ready=0. Then enq_valid=2'b11 with deq_ready=0 → count stays 8, no overwrite. Dequeue order must be 10..17.
- Wrap-around: 6 enq, 6 deq, then 6 more enq (8'hA0..A5) → pointers cross DEPTH. Dequeue yields A0..A5 in order; count returns to 0.
- Mixed widths: with count=3, apply enq_valid=2'b01 plus deq_ready=2'b11 → count=2, head advances 2. Apply enq_valid=2'b11 plus deq_ready=2'b01 → count=3.
- Flush and reset: with count=5, assert flush together with enq_valid=2'b11 → next cycle count=0, deq_valid=0, enq ignored. Repeat with rst instead of flush → identical result.
- Bypass (macro defined): count=0, enq_valid=2'b11 (8'h55,8'h66), deq_ready=2'b01 → same cycle lane0=8'h55 valid. Next cycle count=1, lane0=8'h66. Without the macro, deq_valid=0 in that same cycle.
